// File: rtl/gate_bist.sv
// Built-in self-test for a 7-gate block: walks all four {a,b} vectors and records mismatches.
// Optional `GATE_BIST_ERRCNT_EN adds a saturating per-bit error counter output err_cnt.
module gate_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] gates_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_vec,
  output logic [6:0] fail_mask
`ifdef GATE_BIST_ERRCNT_EN
  ,
  output logic [3:0] err_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APPLY  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [1:0] r_state;
  logic [1:0] r_vec;
  logic [3:0] r_settle;
  logic       r_fail;
  logic [1:0] r_fail_vec;
  logic [6:0] r_fail_mask;

  logic       w_a;
  logic       w_b;
  logic [6:0] w_expect;
  logic [6:0] w_mismatch;

  assign w_a = r_vec[1];
  assign w_b = r_vec[0];

  // Expected order matches gates_i: [6]XNOR [5]XOR [4]NOR [3]NAND [2]NOT [1]OR [0]AND
  always_comb begin
    w_expect   = {~(w_a ^ w_b), w_a ^ w_b, ~(w_a | w_b), ~(w_a & w_b), ~w_a, w_a | w_b, w_a & w_b};
    w_mismatch = gates_i ^ w_expect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_vec       <= '0;
      r_settle    <= '0;
      r_fail      <= 1'b0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= APPLY;
            r_vec       <= '0;
            r_settle    <= SETTLE_LOAD;
            r_fail      <= 1'b0;
            r_fail_vec  <= '0;
            r_fail_mask <= '0;
          end
        end
        APPLY: begin
          if (r_settle <= 4'd1) begin
            r_state  <= SAMPLE;
            r_settle <= '0;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        SAMPLE: begin
          if (|w_mismatch) begin
            r_fail_mask <= r_fail_mask | w_mismatch;
            if (!r_fail) begin
              r_fail     <= 1'b1;
              r_fail_vec <= r_vec;
            end
          end
          // vec returns to 0 on the last vector so a_o/b_o read 0 in DONE and IDLE
          if (r_vec == 2'd3) begin
            r_state <= DONE;
            r_vec   <= '0;
          end else begin
            r_state  <= APPLY;
            r_vec    <= r_vec + 2'd1;
            r_settle <= SETTLE_LOAD;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef GATE_BIST_ERRCNT_EN
  logic [3:0] r_err_cnt;
  logic [2:0] w_pop;
  logic [4:0] w_sum;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      w_pop = w_pop + {2'b00, w_mismatch[i]};
    end
    w_sum = {1'b0, r_err_cnt} + {2'b00, w_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      r_err_cnt <= '0;
    end else if (r_state == SAMPLE) begin
      r_err_cnt <= (w_sum > 5'd15) ? 4'd15 : w_sum[3:0];
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign a_o       = w_a;
  assign b_o       = w_b;
  assign busy      = (r_state == APPLY) || (r_state == SAMPLE);
  assign done      = (r_state == DONE);
  assign fail      = r_fail;
  assign fail_vec  = r_fail_vec;
  assign fail_mask = r_fail_mask;

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, cycles each input vector is held before the gate outputs are sampled; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to run one full self-test pass; sampled only in IDLE.
REQ-005 Port: a_o  input-drive  output  1  stimulus driven to the gate block's a input.
REQ-006 Port: b_o  output  1  stimulus driven to the gate block's b input.
REQ-007 Port: gates_i  input  7  gate results; bit order [0]AND [1]OR [2]NOT [3]NAND [4]NOR [5]XOR [6]XNOR.
REQ-008 Port: busy  output  1  high while a pass is in progress (APPLY/SAMPLE).
REQ-009 Port: done  output  1  one-cycle pulse marking the end of a pass.
REQ-010 Port: fail  output  1  sticky: at least one mismatch in the current/last pass.
REQ-011 Port: fail_vec  output  2  {a,b} of the first failing vector of the pass.
REQ-012 Port: fail_mask  output  7  OR of mismatch bits over all vectors of the pass, same bit order as gates_i.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY, SAMPLE, DONE; IDLE at reset.
REQ-014 IDLE with start=1 SHALL go to APPLY, set vector index vec=0, and clear fail, fail_vec, fail_mask.
REQ-015 a_o SHALL equal vec[1] and b_o SHALL equal vec[0] in every state; both SHALL be 0 in IDLE and DONE.
REQ-016 APPLY SHALL last exactly SETTLE_CYCLES cycles (internal settle counter), then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle: compare gates_i against expected {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b} for the current a_o/b_o.
REQ-018 On any mismatch in SAMPLE: fail_mask |= mismatch bits; if fail was 0, fail_vec <= vec and fail <= 1.
REQ-019 From SAMPLE: vec==3 SHALL go to DONE; otherwise vec increments by 1 and the FSM returns to APPLY with the settle counter reloaded.
REQ-020 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE.
REQ-021 busy SHALL be 1 exactly in APPLY and SAMPLE; a pass occupies 4*(SETTLE_CYCLES+1) busy cycles, done follows in the next cycle.
REQ-022 start SHALL be ignored in APPLY, SAMPLE and DONE; a start held high in DONE is accepted on the following IDLE cycle.
REQ-023 fail, fail_vec and fail_mask SHALL hold their values in IDLE until the next accepted start.
REQ-024 vec SHALL be 2 bits and never wrap within a pass; the settle counter SHALL be 4 bits.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, force state IDLE, vec=0, settle counter=0, a_o=0, b_o=0, busy=0, done=0, fail=0, fail_vec=0, fail_mask=0.
REQ-026 Reset asserted mid-pass SHALL abort the pass with no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-027 Macro GATE_BIST_ERRCNT_EN defined: add output err_cnt (4 bits), cleared on reset and accepted start, incremented by 1 per mismatching gate bit in SAMPLE, saturating at 15.
REQ-028 Macro GATE_BIST_ERRCNT_EN undefined: no err_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-029 Correct gate model, SETTLE_CYCLES=2, start pulse at edge 0 -> busy high 12 cycles, done high in cycle 13, fail=0, fail_mask=7'h00.
REQ-030 XOR output stuck at 0 -> fail=1, fail_vec=2'b01, fail_mask=7'b0100000; err_cnt=2 with GATE_BIST_ERRCNT_EN.
REQ-031 NOT output tied to a instead of ~a -> fail_vec=2'b00, fail_mask=7'b0000100, err_cnt=4.
REQ-032 start re-pulsed during APPLY of vec=2 -> ignored; pass completes at normal done time with unchanged results.
REQ-033 rst_n pulled low in SAMPLE of vec=1 -> all outputs 0 asynchronously, no done; new start then runs a full clean pass.
REQ-034 start held high continuously -> passes repeat back-to-back with one IDLE cycle between done and next busy; results cleared at each start.
